// File: rtl/video_pkg.sv
// Shared video-pipeline types for the framebuffer fetch path.
// FB_FETCH_LINE_REPEAT_EN adds a line-repeat field to the fetch config.
package video_pkg;

   localparam int FB_ADDR_W = 32;
   localparam int FB_LINE_W = 12;
   localparam int FB_REP_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } fetch_state_e;

   // base tracks the start of the line currently being fetched
   typedef struct packed {
      logic [FB_ADDR_W-1:0] base;
      logic [FB_LINE_W-1:0] line_words;
      logic [FB_LINE_W-1:0] line_count;
      logic [FB_LINE_W-1:0] stride;
`ifdef FB_FETCH_LINE_REPEAT_EN
      logic [FB_REP_W-1:0]  rpt;
`endif
   } fb_fetch_cfg_t;

endpackage

// File: rtl/fetch_credit_counter.sv
// Outstanding-request counter and FIFO/space admission check.
module fetch_credit_counter #(
   parameter int FIFO_AWIDTH     = 9,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 issue_i,
   input  logic                 rsp_i,
   input  logic [FIFO_AWIDTH:0] fill_i,
   output logic                 rsp_ok_o,
   output logic                 space_ok_o,
   output logic [FIFO_AWIDTH:0] pending_o,
   output logic [FIFO_AWIDTH:0] pending_next_o
);

   localparam int CW = FIFO_AWIDTH + 1;
   localparam int SW = FIFO_AWIDTH + 2;
   localparam logic [SW-1:0] CAP  = SW'(2 ** FIFO_AWIDTH);
   localparam logic [CW-1:0] MAXO = CW'(MAX_OUTSTANDING);

   logic [CW-1:0] pend_q;
   logic [CW-1:0] pend_d;
   logic [SW-1:0] need;

   // a response with nothing outstanding is stray and dropped
   assign rsp_ok_o = rsp_i & (pend_q != '0);

   always_comb begin
      pend_d = pend_q;
      if (issue_i & ~rsp_ok_o)
         pend_d = pend_q + 1'b1;
      else if (~issue_i & rsp_ok_o)
         pend_d = pend_q - 1'b1;
   end

   assign need = {1'b0, pend_q} + {1'b0, fill_i} + SW'(1);

   assign space_ok_o     = (need <= CAP) & (pend_q < MAXO);
   assign pending_o      = pend_q;
   assign pending_next_o = pend_d;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
         pend_q <= '0;
      else
         pend_q <= pend_d;
   end

endmodule

// File: rtl/fb_fetch_engine.sv
// Framebuffer fetch engine: pipelined Wishbone reader feeding a pixel FIFO.
// Define FB_FETCH_LINE_REPEAT_EN to add repeat_i (each line fetched N+1 times).
module fb_fetch_engine
   import video_pkg::*;
#(
   parameter int DATA_WIDTH      = 128,
   parameter int ADDR_WIDTH      = FB_ADDR_W,
   parameter int FIFO_AWIDTH     = 9,
   parameter int MAX_OUTSTANDING = 8,
   parameter int LINE_W          = FB_LINE_W
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  enable_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] fb_base_i,
   input  logic [LINE_W-1:0]     line_words_i,
   input  logic [LINE_W-1:0]     line_count_i,
   input  logic [LINE_W-1:0]     stride_i,
`ifdef FB_FETCH_LINE_REPEAT_EN
   input  logic [FB_REP_W-1:0]   repeat_i,
`endif
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   output logic [ADDR_WIDTH-1:0] wb_addr_o,
   input  logic                  wb_stall_i,
   input  logic                  wb_ack_i,
   input  logic                  wb_err_i,
   input  logic [DATA_WIDTH-1:0] wb_rdata_i,
   output logic                  ff_we_o,
   output logic [DATA_WIDTH-1:0] ff_wdata_o,
   input  logic [FIFO_AWIDTH:0]  ff_fill_count_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   fetch_state_e          state_q;
   fb_fetch_cfg_t         cfg_q;
   fb_fetch_cfg_t         cfg_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [FB_ADDR_W-1:0]  next_base;
   logic [FB_LINE_W-1:0]  word_q;
   logic [FB_LINE_W-1:0]  line_q;
   logic                  err_q;
   logic                  done_q;
   logic                  we_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   logic [FIFO_AWIDTH:0]  pend;
   logic [FIFO_AWIDTH:0]  pend_next;
   logic                  space_ok;
   logic                  rsp_ok;
   logic                  req_ok;
   logic                  in_fetch;
   logic                  last_word;
   logic                  last_line;
   logic                  last_rep;
   logic                  empty_cfg;

   fetch_credit_counter #(
      .FIFO_AWIDTH    (FIFO_AWIDTH),
      .MAX_OUTSTANDING(MAX_OUTSTANDING)
   ) u_credit (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .issue_i       (req_ok),
      .rsp_i         (wb_ack_i | wb_err_i),
      .fill_i        (ff_fill_count_i),
      .rsp_ok_o      (rsp_ok),
      .space_ok_o    (space_ok),
      .pending_o     (pend),
      .pending_next_o(pend_next)
   );

   assign in_fetch = (state_q == FETCH);
   // dropping enable kills the strobe in the same cycle
   assign wb_stb_o = in_fetch & enable_i & space_ok;
   assign wb_cyc_o = in_fetch | (pend != '0);
   assign req_ok   = wb_cyc_o & wb_stb_o & ~wb_stall_i;

   assign wb_addr_o  = addr_q;
   assign ff_we_o    = we_q;
   assign ff_wdata_o = wdata_q;
   assign busy_o     = (state_q != IDLE);
   assign done_o     = done_q;
   assign err_o      = err_q;

   assign last_word = (word_q == cfg_q.line_words - 1'b1);
   assign last_line = (line_q == cfg_q.line_count - 1'b1);
   assign next_base = cfg_q.base + FB_ADDR_W'(cfg_q.stride);
   assign empty_cfg = (line_words_i == '0) | (line_count_i == '0);

   always_comb begin
      cfg_d            = '0;
      cfg_d.base       = FB_ADDR_W'(fb_base_i);
      cfg_d.line_words = FB_LINE_W'(line_words_i);
      cfg_d.line_count = FB_LINE_W'(line_count_i);
      cfg_d.stride     = FB_LINE_W'(stride_i);
`ifdef FB_FETCH_LINE_REPEAT_EN
      cfg_d.rpt        = repeat_i;
`endif
   end

`ifdef FB_FETCH_LINE_REPEAT_EN
   logic [FB_REP_W-1:0] rep_q;

   assign last_rep = (rep_q == cfg_q.rpt);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
         rep_q <= '0;
      else if (state_q == IDLE)
         rep_q <= '0;
      else if (req_ok & last_word)
         rep_q <= last_rep ? '0 : rep_q + 1'b1;
   end
`else
   assign last_rep = 1'b1;
`endif

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         cfg_q   <= '0;
         addr_q  <= '0;
         word_q  <= '0;
         line_q  <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (rsp_ok & wb_err_i)
            err_q <= 1'b1;
         unique case (state_q)
            IDLE: begin
               if (start_i & enable_i) begin
                  cfg_q  <= cfg_d;
                  addr_q <= fb_base_i;
                  word_q <= '0;
                  line_q <= '0;
                  err_q  <= 1'b0;
                  if (empty_cfg)
                     done_q <= 1'b1;
                  else
                     state_q <= FETCH;
               end
            end
            FETCH: begin
               if (!enable_i) begin
                  state_q <= DRAIN;
               end else if (req_ok) begin
                  if (!last_word) begin
                     addr_q <= addr_q + 1'b1;
                     word_q <= word_q + 1'b1;
                  end else begin
                     word_q <= '0;
                     // replay the same line before moving on
                     if (!last_rep) begin
                        addr_q <= ADDR_WIDTH'(cfg_q.base);
                     end else if (last_line) begin
                        state_q <= DRAIN;
                     end else begin
                        line_q     <= line_q + 1'b1;
                        cfg_q.base <= next_base;
                        addr_q     <= ADDR_WIDTH'(next_base);
                     end
                  end
               end
            end
            DRAIN: begin
               if (pend_next == '0) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // every accepted beat is written, errors as zero to keep alignment
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         we_q <= rsp_ok;
         if (rsp_ok)
            wdata_q <= wb_err_i ? '0 : wb_rdata_i;
      end
   end

endmodule

// File: tb/tb_fb_fetch_engine.sv
// Bench for fb_fetch_engine: address/FIFO model checked every cycle.
// Build with FB_FETCH_LINE_REPEAT_EN to also cover line repeat.
module tb_fb_fetch_engine;

   localparam int DW = 128;
   localparam int AW = 32;
   localparam int FA = 4;
   localparam int MO = 8;
   localparam int LW = 12;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          enable = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] fb_base = '0;
   logic [LW-1:0] line_words = '0;
   logic [LW-1:0] line_count = '0;
   logic [LW-1:0] stride = '0;
   logic [3:0]    rpt = '0;
   logic          wb_cyc;
   logic          wb_stb;
   logic [AW-1:0] wb_addr;
   logic          wb_stall = 1'b0;
   logic          wb_ack = 1'b0;
   logic          wb_err = 1'b0;
   logic [DW-1:0] wb_rdata = '0;
   logic          ff_we;
   logic [DW-1:0] ff_wdata;
   logic [FA:0]   ff_fill = '0;
   logic          busy;
   logic          done;
   logic          err;

   always #5 clk = ~clk;

   fb_fetch_engine #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_AWIDTH(FA),
      .MAX_OUTSTANDING(MO), .LINE_W(LW)
   ) dut (
      .clk_i(clk), .rstn_i(rstn), .enable_i(enable), .start_i(start),
      .fb_base_i(fb_base), .line_words_i(line_words),
      .line_count_i(line_count), .stride_i(stride),
`ifdef FB_FETCH_LINE_REPEAT_EN
      .repeat_i(rpt),
`endif
      .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_addr_o(wb_addr),
      .wb_stall_i(wb_stall), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
      .wb_rdata_i(wb_rdata), .ff_we_o(ff_we), .ff_wdata_o(ff_wdata),
      .ff_fill_count_i(ff_fill), .busy_o(busy), .done_o(done), .err_o(err)
   );

   int checks = 0;
   int failures = 0;

   logic [AW-1:0] exp_addr[$];
   logic [AW-1:0] inflight[$];
   logic [AW-1:0] seen_addr[$];
   logic [DW-1:0] exp_data[$];
   logic [DW-1:0] ff_seen[$];

   int issued = 0;
   int pend_m = 0;
   int p0;
   int rsp_cnt = 0;
   int rsp_limit = 0;
   int err_at = 0;
   int stall_at = 0;
   int stall_left = 0;
   int cyc_n = 0;
   int last_rsp_cyc = 0;
   logic          req_n = 1'b0;
   logic          rsp_n = 1'b0;
   logic          prev_valid = 1'b0;
   logic [AW-1:0] req_a = '0;
   logic [AW-1:0] pop_a;

   task automatic chk(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk(input logic [AW-1:0] a);
      return {a, ~a, a ^ 32'hA5A5_5A5A, a + 32'h1234_5678};
   endfunction

   // slave + model bookkeeping, just after each active edge
   always @(posedge clk) begin
      #1;
      cyc_n++;
      p0 = pend_m;
      if (req_n) begin
         inflight.push_back(req_a);
         seen_addr.push_back(req_a);
         issued++;
      end
      pend_m = p0 + (req_n ? 1 : 0) - ((rsp_n && p0 > 0) ? 1 : 0);
      wb_ack = 1'b0;
      wb_err = 1'b0;
      wb_rdata = '0;
      if (inflight.size() > 0 && rsp_cnt < rsp_limit) begin
         pop_a = inflight.pop_front();
         rsp_cnt++;
         if (rsp_cnt == err_at) begin
            wb_err = 1'b1;
            wb_rdata = {4{32'hDEAD_BEEF}};
            exp_data.push_back('0);
         end else begin
            wb_ack = 1'b1;
            wb_rdata = mk(pop_a);
            exp_data.push_back(mk(pop_a));
         end
      end
      if (stall_left > 0 && issued == stall_at - 1) begin
         wb_stall = 1'b1;
         stall_left--;
      end else begin
         wb_stall = 1'b0;
      end
   end

   // per-cycle compare, mid-cycle
   always @(negedge clk) begin
      if (prev_valid) begin
         chk("ff_we", ff_we, 1);
         if (exp_data.size() > 0) begin
            chk("ff_wdata", ff_wdata, exp_data.pop_front());
         end else begin
            checks++;
            failures++;
            $display("FAIL ff_unexpected actual=%0h required=none", ff_wdata);
         end
      end else begin
         chk("ff_we_idle", ff_we, 0);
      end
      if (ff_we) ff_seen.push_back(ff_wdata);
      prev_valid = (wb_ack | wb_err) && pend_m > 0;
      if (prev_valid) last_rsp_cyc = cyc_n;
      req_n = wb_cyc & wb_stb & ~wb_stall;
      req_a = wb_addr;
      rsp_n = wb_ack | wb_err;
      if (wb_cyc & wb_stb) begin
         if (issued < exp_addr.size()) begin
            chk("wb_addr", wb_addr, exp_addr[issued]);
         end else begin
            checks++;
            failures++;
            $display("FAIL stb_extra actual=%0h required=no_strobe", wb_addr);
         end
         chk("space_rule", (pend_m + int'(ff_fill) + 1 <= 2 ** FA) && (pend_m < MO), 1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic setup(input logic [AW-1:0] b, input int w, input int l,
                        input int s, input int r);
      exp_addr.delete();
      seen_addr.delete();
      ff_seen.delete();
      for (int li = 0; li < l; li++)
         for (int ri = 0; ri <= r; ri++)
            for (int wi = 0; wi < w; wi++)
               exp_addr.push_back(b + AW'(li * s + wi));
      issued = 0;
      rsp_cnt = 0;
      rsp_limit = 1000;
      err_at = 0;
      stall_left = 0;
      fb_base = b;
      line_words = LW'(w);
      line_count = LW'(l);
      stride = LW'(s);
      rpt = 4'(r);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            at = cyc_n;
            break;
         end
      end
      checks++;
      if (at < 0) begin
         failures++;
         $display("FAIL done_timeout actual=none required=done_pulse");
      end
      #1;
   endtask

   int at;
   logic got;

   initial begin
      #50000;
      $display("FAIL watchdog actual=hang required=finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_outs", {wb_cyc, wb_stb, wb_addr, ff_we, ff_wdata, busy, done, err}, 0);
      tick();
      rstn = 1'b1;
      enable = 1'b1;
      tick();

      // T1: zero-wait slave, 4x3 stride 8
      setup(32'h100, 4, 3, 8, 0);
      pulse_start();
      chk("t1_busy", busy, 1);
      wait_done(200, at);
      chk("t1_done_lat", at, last_rsp_cyc + 1);
      chk("t1_issued", issued, 12);
      chk("t1_ff_cnt", ff_seen.size(), 12);
      chk("t1_addr0", seen_addr[0], 32'h100);
      chk("t1_addr4", seen_addr[4], 32'h108);
      chk("t1_addr11", seen_addr[11], 32'h113);
      chk("t1_data0_hi", ff_seen[0][127:96], 32'h100);
      @(negedge clk);
      chk("t1_done_pulse", done, 0);
      chk("t1_idle", busy, 0);
      chk("t1_err", err, 0);

      // T2: fill held at 14 with no responses
      tick();
      setup(32'h100, 4, 3, 8, 0);
      ff_fill = 5'd14;
      rsp_limit = 0;
      pulse_start();
      repeat (10) tick();
      chk("t2_issued_cap", issued, 2);
      chk("t2_busy", busy, 1);
      ff_fill = '0;
      rsp_limit = 1000;
      wait_done(200, at);
      chk("t2_issued", issued, 12);
      chk("t2_ff_cnt", ff_seen.size(), 12);

      // T3: 5-cycle stall on the 2nd request, start while busy
      tick();
      setup(32'h100, 4, 3, 8, 0);
      stall_at = 2;
      stall_left = 5;
      pulse_start();
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = wb_stall;
      end
      chk("t3_stall_seen", got, 1);
      for (int k = 0; k < 5; k++) begin
         chk("t3_hold_addr", wb_addr, 32'h101);
         chk("t3_hold_stb", wb_stb, 1);
         @(negedge clk);
      end
      fb_base = 32'h500;
      pulse_start();
      wait_done(200, at);
      chk("t3_issued", issued, 12);
      chk("t3_ff_cnt", ff_seen.size(), 12);
      chk("t3_addr2", seen_addr[2], 32'h102);

      // T4: error on the 3rd beat
      tick();
      setup(32'h100, 4, 3, 8, 0);
      err_at = 3;
      pulse_start();
      wait_done(200, at);
      chk("t4_err_data", ff_seen[2], 0);
      chk("t4_data3_hi", ff_seen[3][127:96], 32'h103);
      chk("t4_err", err, 1);
      repeat (3) tick();
      chk("t4_err_sticky", err, 1);

      // T5: abort after 5 issues with 3 outstanding
      setup(32'h100, 4, 3, 8, 0);
      rsp_limit = 2;
      pulse_start();
      chk("t5_err_clr", err, 0);
      for (int i = 0; i < 50 && issued < 5; i++) tick();
      enable = 1'b0;
      chk("t5_issued5", issued, 5);
      repeat (4) tick();
      chk("t5_no_strobe", issued, 5);
      chk("t5_ff_before", ff_seen.size(), 2);
      chk("t5_draining", busy, 1);
      rsp_limit = 1000;
      wait_done(100, at);
      chk("t5_ff_cnt", ff_seen.size(), 5);
      @(negedge clk);
      chk("t5_idle", busy, 0);
      tick();
      enable = 1'b1;

      // T6: empty frame
      setup(32'h200, 0, 3, 8, 0);
      pulse_start();
      chk("t6_done", done, 1);
      chk("t6_busy", busy, 0);
      tick();
      chk("t6_done_pulse", done, 0);
      chk("t6_issued", issued, 0);

      // T7: start with enable low
      setup(32'h200, 4, 3, 8, 0);
      enable = 1'b0;
      pulse_start();
      tick();
      chk("t7_ignored", busy, 0);
      chk("t7_issued", issued, 0);
      enable = 1'b1;
      tick();

`ifdef FB_FETCH_LINE_REPEAT_EN
      // T8: each line fetched twice
      setup(32'h0, 2, 2, 4, 1);
      pulse_start();
      wait_done(200, at);
      chk("t8_issued", issued, 8);
      chk("t8_addr2", seen_addr[2], 32'h0);
      chk("t8_addr3", seen_addr[3], 32'h1);
      chk("t8_addr6", seen_addr[6], 32'h4);
      chk("t8_ff_cnt", ff_seen.size(), 8);
      tick();
`endif

      chk("final_queue", exp_data.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
